// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one i2c_master command/response port between N_REQ requesters.
// Grants one requester, issues its command, waits for the response or a timeout, then reports the result.
module i2c_txn_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int IDX_W          = $clog2(N_REQ)
) (
    input  logic                 ck,
    input  logic                 arst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_rnw,
    input  logic [7*N_REQ-1:0]   req_dev_addr,
    input  logic [8*N_REQ-1:0]   req_reg_addr,
    input  logic [8*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     req_done,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_nack,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic [IDX_W-1:0]     owner,
    output logic                 m_cmd_valid,
    input  logic                 m_cmd_ready,
    output logic                 m_rnw,
    output logic [6:0]           m_dev_addr,
    output logic [7:0]           m_reg_addr,
    output logic [7:0]           m_wdata,
    input  logic                 m_rsp_valid,
    input  logic [7:0]           m_rsp_rdata,
    input  logic                 m_rsp_nack
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               rnw_q, rnw_d;
    logic [6:0]         dev_q, dev_d;
    logic [7:0]         reg_q, reg_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [N_REQ-1:0]   ready_q, ready_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               nack_q, nack_d;
    logic               timeout_q, timeout_d;

    logic               found_hi, found_lo, found;
    logic [IDX_W-1:0]   win_hi, win_lo, winner;
    logic               sel_rnw;
    logic [6:0]         sel_dev;
    logic [7:0]         sel_reg, sel_wdata;

    // Round-robin search: indices above last first, then wrap around to 0..last.
    always_comb begin
        found_hi  = 1'b0;
        found_lo  = 1'b0;
        win_hi    = '0;
        win_lo    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_hi && req_valid[i] && (IDX_W'(i) > last_q)) begin
                found_hi = 1'b1;
                win_hi   = IDX_W'(i);
            end
            if (!found_lo && req_valid[i] && (IDX_W'(i) <= last_q)) begin
                found_lo = 1'b1;
                win_lo   = IDX_W'(i);
            end
        end
        found     = found_hi || found_lo;
        winner    = found_hi ? win_hi : win_lo;
        sel_rnw   = 1'b0;
        sel_dev   = '0;
        sel_reg   = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == winner) begin
                sel_rnw   = req_rnw[i];
                sel_dev   = req_dev_addr[7*i +: 7];
                sel_reg   = req_reg_addr[8*i +: 8];
                sel_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        count_d     = count_q;
        cmd_valid_d = cmd_valid_q;
        rnw_d       = rnw_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        ready_d     = '0;
        rdata_d     = rdata_q;
        nack_d      = nack_q;
        timeout_d   = timeout_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d     = S_ISSUE;
                    owner_d     = winner;
                    cmd_valid_d = 1'b1;
                    rnw_d       = sel_rnw;
                    dev_d       = sel_dev;
                    reg_d       = sel_reg;
                    wdata_d     = sel_wdata;
                    count_d     = '0;
                    for (int i = 0; i < N_REQ; i++) begin
                        ready_d[i] = (IDX_W'(i) == winner);
                    end
                end
            end
            S_ISSUE: begin
                count_d = count_q + CNT_W'(1);
                if (cmd_valid_q && m_cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_WAIT;
                end else if (count_q == CNT_LAST) begin
                    cmd_valid_d = 1'b0;
                    rdata_d     = 8'h00;
                    nack_d      = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_WAIT: begin
                count_d = count_q + CNT_W'(1);
                // A response landing on the final count beats the timeout.
                if (m_rsp_valid) begin
                    rdata_d   = (rnw_q && !m_rsp_nack) ? m_rsp_rdata : 8'h00;
                    nack_d    = m_rsp_nack;
                    timeout_d = 1'b0;
                    state_d   = S_DONE;
                end else if (count_q == CNT_LAST) begin
                    rdata_d   = 8'h00;
                    nack_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge arst) begin
        if (!arst) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            count_q     <= '0;
            cmd_valid_q <= 1'b0;
            rnw_q       <= 1'b0;
            dev_q       <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            ready_q     <= '0;
            rdata_q     <= '0;
            nack_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            count_q     <= count_d;
            cmd_valid_q <= cmd_valid_d;
            rnw_q       <= rnw_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            nack_q      <= nack_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        req_done = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_done[i] = (state_q == S_DONE) && (owner_q == IDX_W'(i));
        end
    end

    assign req_ready   = ready_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_nack    = nack_q;
    assign rsp_timeout = timeout_q;
    assign busy        = (state_q != S_IDLE);
    assign owner       = owner_q;
    assign m_cmd_valid = cmd_valid_q;
    assign m_rnw       = rnw_q;
    assign m_dev_addr  = dev_q;
    assign m_reg_addr  = reg_q;
    assign m_wdata     = wdata_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: directed scenarios plus randomized transactions against a
// transaction-level model of the round-robin grant order and response rules.
module tb_i2c_txn_arbiter;

    localparam int N  = 4;
    localparam int T  = 16;
    localparam int IW = 2;

    logic           ck = 1'b0;
    logic           arst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_rnw = '0;
    logic [7*N-1:0] req_dev_addr = '0;
    logic [8*N-1:0] req_reg_addr = '0;
    logic [8*N-1:0] req_wdata = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_done;
    logic [7:0]     rsp_rdata;
    logic           rsp_nack;
    logic           rsp_timeout;
    logic           busy;
    logic [IW-1:0]  owner;
    logic           m_cmd_valid;
    logic           m_cmd_ready = 1'b0;
    logic           m_rnw;
    logic [6:0]     m_dev_addr;
    logic [7:0]     m_reg_addr;
    logic [7:0]     m_wdata;
    logic           m_rsp_valid = 1'b0;
    logic [7:0]     m_rsp_rdata = '0;
    logic           m_rsp_nack = 1'b0;

    i2c_txn_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .ck(ck), .arst(arst),
        .req_valid(req_valid), .req_rnw(req_rnw), .req_dev_addr(req_dev_addr),
        .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .req_done(req_done),
        .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
        .busy(busy), .owner(owner),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_rnw(m_rnw),
        .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr), .m_wdata(m_wdata),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .m_rsp_nack(m_rsp_nack)
    );

    always #5 ck = ~ck;

    int total = 0;
    int bad   = 0;

    // Model: pending request per requester and the last served index.
    bit         pend[N];
    logic       rnw_m[N];
    logic [6:0] dev_m[N];
    logic [7:0] reg_m[N];
    logic [7:0] wd_m[N];
    int         last_m;
    int         obs_owner;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int i, input logic rnw, input logic [6:0] dev,
                        input logic [7:0] ra, input logic [7:0] wd);
        pend[i]  = 1'b1;
        rnw_m[i] = rnw;
        dev_m[i] = dev;
        reg_m[i] = ra;
        wd_m[i]  = wd;
    endtask

    task automatic post_rand(input int i);
        post(i, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pend[i];
            req_rnw[i]            = rnw_m[i];
            req_dev_addr[7*i +: 7] = dev_m[i];
            req_reg_addr[8*i +: 8] = reg_m[i];
            req_wdata[8*i +: 8]    = wd_m[i];
        end
    endtask

    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            if (pend[(last_m + k) % N]) return (last_m + k) % N;
        end
        return 0;
    endfunction

    // mode 0 normal, 1 nack, 2 timeout (no response), 3 response on the final allowed cycle.
    // d1 = cycle of the command handshake (>= T means never), d2 = gap before the response.
    task automatic do_txn(input int mode, input int d1, input int d2, input logic [7:0] rd);
        int w, lat, rc, endc;
        logic [23:0] fields;
        logic [7:0]  exp_rd;
        logic        exp_nack, exp_to;
        drive();
        w = pick();
        fields = {rnw_m[w], dev_m[w], reg_m[w], wd_m[w]};
        lat = 0;
        do begin
            tick();
            lat++;
        end while (req_ready == '0 && lat < 8);
        obs_owner = int'(owner);
        chk("grant_latency", lat, 1);
        chk("req_ready", req_ready, 32'(1 << w));
        chk("owner", owner, w);
        chk("cmd_valid_grant", m_cmd_valid, 1);
        chk("busy_grant", busy, 1);
        chk("m_fields", {m_rnw, m_dev_addr, m_reg_addr, m_wdata}, fields);
        pend[w] = 1'b0;
        drive();
        rc   = (mode == 2) ? -1 : (mode == 3) ? T - 1 : d1 + 1 + d2;
        endc = (mode == 2) ? T - 1 : rc;
        for (int c = 0; c <= endc; c++) begin
            m_cmd_ready = (c == d1);
            m_rsp_valid = (c == rc);
            m_rsp_rdata = rd;
            m_rsp_nack  = (mode == 1);
            if (c == d1) begin
                chk("cmd_valid_hold", m_cmd_valid, 1);
                chk("m_fields_stable", {m_rnw, m_dev_addr, m_reg_addr, m_wdata}, fields);
            end
            tick();
        end
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_nack  = 1'b0;
        if (mode == 2) begin
            exp_rd = 8'h00; exp_nack = 1'b1; exp_to = 1'b1;
        end else if (mode == 1) begin
            exp_rd = 8'h00; exp_nack = 1'b1; exp_to = 1'b0;
        end else begin
            exp_rd = fields[23] ? rd : 8'h00; exp_nack = 1'b0; exp_to = 1'b0;
        end
        chk("req_done", req_done, 32'(1 << w));
        chk("busy_done", busy, 1);
        chk("cmd_valid_done", m_cmd_valid, 0);
        chk("rsp", {rsp_rdata, rsp_nack, rsp_timeout}, {exp_rd, exp_nack, exp_to});
        if (mode == 2) begin
            m_rsp_valid = 1'b1;
            m_rsp_rdata = 8'h3C;
        end
        tick();
        m_rsp_valid = 1'b0;
        chk("done_pulse_end", req_done, 0);
        chk("busy_idle", busy, 0);
        chk("rsp_hold", {rsp_rdata, rsp_nack, rsp_timeout}, {exp_rd, exp_nack, exp_to});
        last_m = w;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; rnw_m[i] = 1'b0; dev_m[i] = '0; reg_m[i] = '0; wd_m[i] = '0;
        end
        last_m = N - 1;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_cmd_valid", m_cmd_valid, 0);
        chk("rst_owner", owner, 0);
        chk("rst_ready_done", {req_ready, req_done}, 0);
        chk("rst_rsp", {rsp_rdata, rsp_nack, rsp_timeout}, 0);
        chk("rst_m_fields", {m_rnw, m_dev_addr, m_reg_addr, m_wdata}, 0);
        arst = 1'b1;
        tick();

        // Single write from requester 2
        post(2, 1'b0, 7'h50, 8'h10, 8'hA5);
        do_txn(0, 0, 9, 8'h5A);
        // Read from requester 0
        post(0, 1'b1, 7'h68, 8'h75, 8'h00);
        do_txn(0, 1, 3, 8'h71);
        chk("read_owner", obs_owner, 0);
        // NACK on a read
        post(1, 1'b1, 7'h22, 8'h01, 8'h00);
        do_txn(1, 0, 2, 8'hFF);
        // Timeouts: in WAIT, in ISSUE, then a response on the last cycle
        post(3, 1'b1, 7'h11, 8'h20, 8'h00);
        do_txn(2, 0, 0, 8'h99);
        post(2, 1'b0, 7'h12, 8'h21, 8'h33);
        do_txn(2, 99, 0, 8'h00);
        post(0, 1'b1, 7'h13, 8'h22, 8'h00);
        do_txn(3, 2, 0, 8'hC4);

        // Reset while waiting for a response
        post(1, 1'b1, 7'h44, 8'h55, 8'h00);
        drive();
        tick();
        pend[1] = 1'b0;
        drive();
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        tick();
        chk("pre_reset_busy", busy, 1);
        arst = 1'b0;
        #1;
        chk("arst_cmd_valid", m_cmd_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_req_done", req_done, 0);
        chk("arst_owner", owner, 0);
        tick();
        arst = 1'b1;
        last_m = N - 1;
        tick();

        // Round robin with all requesters held valid
        for (int i = 0; i < N; i++) post_rand(i);
        for (int k = 0; k < 5; k++) begin
            do_txn(0, $urandom_range(0, 3), $urandom_range(0, 5), 8'($urandom));
            chk("rr_order", obs_owner, k % N);
            post_rand(last_m);
        end

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) post_rand(i);
                any |= pend[i];
            end
            if (!any) post_rand($urandom_range(0, N - 1));
            do_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
